// File: rtl/video_pkg.sv
// Shared video types for the CSI-2 to DVI path: RGB888 pixel, nominal
// resolution and the line-buffer FSM encoding.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int unsigned HRES = 640;
  localparam int unsigned VRES = 480;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream
  } lbuf_state_t;

endpackage

// File: rtl/rgb_sync_fifo.sv
// Single-clock RGB888 FIFO with a registered-read RAM. Occupancy is tracked
// explicitly so full/empty never depend on pointer comparison.
module rgb_sync_fifo
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  rgb888_t       wr_data,
  input  logic          rd_en,
  output rgb888_t       rd_data,
  input  logic          flush,
  output logic [LW-1:0] level
);

  rgb888_t       mem [DEPTH];
  rgb888_t       rd_data_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(wr_en) - LW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // RAM has no reset; a write and read of the same slot returns the old entry.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr_q] <= wr_data;
    if (rd_en && !flush) rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;

endmodule

// File: rtl/csi_pixel_line_buffer.sv
// Elastic pixel buffer between the CSI-2 RGB unpacker and the DVI output:
// frame-aligned fill, one-cycle request-to-data, black on underrun.
module csi_pixel_line_buffer
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned START_LEVEL = 640,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic          clk_pix,
  input  logic          RST_N,
  input  logic [23:0]   rgb_in,
  input  logic          rgb_in_valid,
  input  logic          sof_in,
  input  logic          pixel_request,
  input  logic          flag_clr,
  output logic [23:0]   RGB_data_out,
  output logic          RGB_out_valid,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          underflow
);

  lbuf_state_t   state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic          sel_black_q, sel_black_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          full, empty, req_act, pop, underrun, overrun, wr;
  logic [LW-1:0] fifo_level;
  rgb888_t       fifo_rd_data;

  rgb_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_pix),
    .rst_n   (RST_N),
    .wr_en   (wr),
    .wr_data (rgb888_t'(rgb_in)),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .flush   (overrun),
    .level   (fifo_level)
  );

  always_comb begin
    full     = fifo_level == LW'(DEPTH);
    empty    = fifo_level == '0;
    req_act  = (state_q == StStream) && pixel_request;
    pop      = req_act && !empty;
    underrun = req_act && empty;
    // A pop in the same cycle makes room, so a write at full is then legal.
    overrun  = (state_q != StIdle) && rgb_in_valid && full && !pop;
    wr       = (state_q == StIdle) ? (rgb_in_valid && sof_in) : (rgb_in_valid && !overrun);

    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rgb_in_valid && sof_in) state_d = StFill;
      StFill:   if (fifo_level >= LW'(START_LEVEL)) state_d = StStream;
      StStream: state_d = StStream;
      default:  state_d = StIdle;
    endcase
    if (overrun) state_d = StIdle;

    out_valid_d = req_act;
    sel_black_d = sel_black_q;
    if (underrun) sel_black_d = 1'b1;
    else if (pop) sel_black_d = 1'b0;

    ovf_d = ovf_q;
    if (overrun) ovf_d = 1'b1;
    else if (flag_clr) ovf_d = 1'b0;

    unf_d = unf_q;
    if (underrun) unf_d = 1'b1;
    else if (flag_clr) unf_d = 1'b0;
  end

  // sel_black resets high so the output reads zero before any pop.
  always_ff @(posedge clk_pix or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      sel_black_q <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      sel_black_q <= sel_black_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign RGB_data_out  = sel_black_q ? 24'h000000 : fifo_rd_data;
  assign RGB_out_valid = out_valid_q;
  assign level         = fifo_level;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_csi_pixel_line_buffer.sv
// Scoreboard bench: a queue-based model predicts every output pixel, the
// occupancy and the sticky flags; a negedge monitor compares.
module tb_csi_pixel_line_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned START = 8;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          RST_N;
  logic [23:0]   rgb_in = '0;
  logic          rgb_in_valid = 1'b0;
  logic          sof_in = 1'b0;
  logic          pixel_request = 1'b0;
  logic          flag_clr = 1'b0;
  logic [23:0]   RGB_data_out;
  logic          RGB_out_valid;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  csi_pixel_line_buffer #(
    .DEPTH       (DEPTH),
    .START_LEVEL (START)
  ) dut (
    .clk_pix       (clk),
    .RST_N         (RST_N),
    .rgb_in        (rgb_in),
    .rgb_in_valid  (rgb_in_valid),
    .sof_in        (sof_in),
    .pixel_request (pixel_request),
    .flag_clr      (flag_clr),
    .RGB_data_out  (RGB_data_out),
    .RGB_out_valid (RGB_out_valid),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  int          total = 0;
  int          bad = 0;
  int          mode = 0;  // 0 idle, 1 fill, 2 stream
  logic [23:0] mq[$];
  logic [23:0] exp_q[$];
  bit          mvalid = 1'b0;
  bit          movf = 1'b0;
  bit          munf = 1'b0;
  logic [23:0] last_seen = '0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit sof, input logic [23:0] px, input bit req,
                            input bit clr);
    int sz;
    bit req_s, popping, ovf;
    sz      = mq.size();
    req_s   = (mode == 2) && req;
    popping = req_s && (sz > 0);
    ovf     = (mode != 0) && v && (sz == int'(DEPTH)) && !popping;
    mvalid  = req_s;
    if (req_s) begin
      if (popping) exp_q.push_back(mq.pop_front());
      else exp_q.push_back(24'h000000);
    end
    if (ovf) begin
      mq.delete();
      mode = 0;
    end else begin
      case (mode)
        0: if (v && sof) begin
          mq.push_back(px);
          mode = 1;
        end
        1: begin
          if (sz >= int'(START)) mode = 2;
          if (v) mq.push_back(px);
        end
        default: if (v) mq.push_back(px);
      endcase
    end
    if (ovf) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (req_s && !popping) munf = 1'b1;
    else if (clr) munf = 1'b0;
  endtask

  task automatic drive(input bit v, input bit sof, input logic [23:0] px, input bit req,
                       input bit clr);
    @(negedge clk);
    rgb_in_valid  = v;
    sof_in        = sof;
    rgb_in        = px;
    pixel_request = req;
    flag_clr      = clr;
    @(posedge clk);
    model_step(v, sof, px, req, clr);
  endtask

  task automatic apply_reset();
    chk_en        = 1'b0;
    RST_N         = 1'b0;
    rgb_in_valid  = 1'b0;
    sof_in        = 1'b0;
    pixel_request = 1'b0;
    flag_clr      = 1'b0;
    #1;
    check("rst_valid", 32'(RGB_out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_data", 32'(RGB_data_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    mode = 0;
    mq.delete();
    exp_q.delete();
    mvalid    = 1'b0;
    movf      = 1'b0;
    munf      = 1'b0;
    last_seen = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST_N = 1'b1;
    #1 chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(RGB_out_valid), 32'(mvalid));
      if (mvalid) begin
        if (exp_q.size() == 0) begin
          check("sb_underrun", 1, 0);
        end else begin
          last_seen = exp_q.pop_front();
          check("data", 32'(RGB_data_out), 32'(last_seen));
        end
      end else begin
        check("hold", 32'(RGB_data_out), 32'(last_seen));
      end
      check("level", 32'(level), mq.size());
      check("overflow", 32'(overflow), 32'(movf));
      check("underflow", 32'(underflow), 32'(munf));
    end
  end

  initial begin
    RST_N = 1'b1;
    #3;
    apply_reset();

    // Pixels before SOF are discarded; SOF pixel must be the first out.
    repeat (20) drive(1'b1, 1'b0, 24'($urandom()), 1'($urandom() % 2), 1'b0);
    drive(1'b1, 1'b1, 24'h000001, 1'b0, 1'b0);
    repeat (20) drive(1'b1, 1'b0, 24'($urandom()), 1'b1, 1'b0);

    // Steady one-in one-out.
    repeat (60) drive(1'b1, 1'b0, 24'($urandom()), 1'b1, 1'b0);

    // Drain to two entries, then request three times.
    for (int g = 0; g < 64 && mq.size() > 2; g++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Overflow from empty stream, then SOF refill to full.
    repeat (17) drive(1'b1, 1'b0, 24'($urandom()), 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 24'($urandom()), 1'b0, 1'b0);
    repeat (15) drive(1'b1, 1'b0, 24'($urandom()), 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    // Full with simultaneous pop and write.
    drive(1'b1, 1'b0, 24'($urandom()), 1'b1, 1'b0);
    repeat (6) drive(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Random traffic.
    repeat (400) drive(1'($urandom() % 4 != 0), 1'($urandom() % 32 == 0), 24'($urandom()),
                       1'($urandom() % 3 != 0), 1'($urandom() % 50 == 0));

    // Reach stream with a live request, then reset between edges.
    drive(1'b1, 1'b1, 24'($urandom()), 1'b0, 1'b0);
    repeat (12) drive(1'b1, 1'b0, 24'($urandom()), 1'b1, 1'b0);
    #2;
    check("pre_rst_valid", 32'(RGB_out_valid), 1);
    apply_reset();
    repeat (10) drive(1'b1, 1'b0, 24'($urandom()), 1'b1, 1'b0);
    drive(1'b1, 1'b1, 24'($urandom()), 1'b0, 1'b0);
    repeat (20) drive(1'b1, 1'b0, 24'($urandom()), 1'($urandom() % 2), 1'b0);
    repeat (5) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csi_pixel_line_buffer.md
# csi_pixel_line_buffer

Elastic pixel buffer between the CSI-2 RGB unpack path and the DVI video output controller. It absorbs bursty RGB888 pixels from the camera side and returns them one per `pixel_request` to the output stage, one cycle after each request. It aligns streaming to a frame start and holds its valid output low until enough pixels are buffered. It also reports overflow and underflow so frame tearing can be diagnosed.

## Interface
Parameters:
- `DEPTH`, 1024: FIFO entries; power of two, ≥ `START_LEVEL`.
- `START_LEVEL`, 640: buffered pixels required before streaming starts (one 640-px line).
- `LW`, `$clog2(DEPTH)+1`: width of the `level` port (local, derived).

Ports:
- `clk_pix`  in  1  pixel clock; all logic is on this one clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `rgb_in`  in  24  pixel from the unpacker, {R[23:16], G[15:8], B[7:0]}.
- `rgb_in_valid`  in  1  `rgb_in` is valid this cycle; no back-pressure.
- `sof_in`  in  1  first pixel of a frame; qualified by `rgb_in_valid`.
- `pixel_request`  in  1  downstream consumes one pixel (display-enable active).
- `flag_clr`  in  1  synchronous clear of the sticky flags.
- `RGB_data_out`  out  24  pixel to the output controller.
- `RGB_out_valid`  out  1  `RGB_data_out` is valid this cycle.
- `level`  out  LW  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a request was made while empty.

## Operation
- FSM states: `IDLE`, `FILL`, `STREAM`.
- `IDLE`:
  - Discards every pixel until `rgb_in_valid & sof_in`.
  - That pixel is written, and the FSM moves to `FILL`.
  - Requests are ignored; no output is produced.
- `FILL`:
  - Writes every valid pixel; `sof_in` is ignored.
  - Moves to `STREAM` in the cycle after `level` ≥ `START_LEVEL`.
  - Requests are ignored; `RGB_out_valid` stays 0.
- `STREAM`:
  - Writes every valid pixel.
  - Each `pixel_request` pops one entry.
  - A request while empty outputs 24'h000000 with valid = 1 and sets `underflow`. The FSM stays in `STREAM`, keeping the downstream pixel cadence.
- Overflow (write while `level == DEPTH` and no pop that cycle), in any state except `IDLE`:
  - The pixel is dropped and `overflow` is set.
  - The FIFO is flushed (`level` goes to 0 next cycle) and the FSM returns to `IDLE`.
- Simultaneous write and pop:
  - When full, both happen and `level` is unchanged; this is not an overflow.
  - When empty, the pop underflows (no bypass), the write is stored, and `level` becomes 1.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are derived from `level`, not from pointer equality.
- `flag_clr` clears both flags. If clear and set coincide, set wins.
- Reset mid-operation: the FSM goes to `IDLE`, pointers, `level` and flags go to 0, and `RGB_out_valid` goes to 0 on the `RST_N` falling edge.

## Timing
- Reset values: `RGB_data_out` = 0, `RGB_out_valid` = 0, `level` = 0, `overflow` = 0, `underflow` = 0, FSM = `IDLE`.
- Read latency is 1. A `pixel_request` accepted in cycle N gives `RGB_data_out` and `RGB_out_valid` = 1 in N+1. Without a request in N, valid is 0 in N+1.
- Outputs are registered; `RGB_data_out` holds its last value while valid is 0.
- `level` is registered and reflects the writes and pops of cycle N in N+1.
- Minimum `sof_in` to first valid output: `START_LEVEL` writes + 1 cycle (transition) + 1 request cycle + 1 latency cycle.
- Write-to-readable latency is 1 cycle: data written in N can be popped in N+1.

## Structure
- Shared package `video_pkg`:
  - `rgb888_t` (24-bit packed R/G/B).
  - `HRES` = 640 and `VRES` = 480.
  - The FSM state encoding `lbuf_state_t`.
- Sub-module `rgb_sync_fifo`:
  - Single-clock FIFO with a registered-read block RAM of `DEPTH` × 24.
  - Ports: `wr_en`, `rd_en`, `flush`, `level`.
- The top level holds the FSM, the flags and the black-pixel substitution.

## Test plan
- Startup: 700 valid pixels without `sof_in`, then `sof_in` with value 24'h000001 -> `level` stays 0 before SOF; first output is 24'h000001 only after 640 writes and the transition cycle.
- Steady stream: continuous write plus request at 1 pixel/cycle with `START_LEVEL` = 640 -> output equals input order exactly; `level` holds at 640 ± 1; no flags.
- Underflow: in `STREAM` with `level` = 2, request 3 cycles without writes -> two pixels, then 24'h000000 with valid = 1; `underflow` = 1 and stays set until `flag_clr`.
- Overflow: `DEPTH` = 16, `START_LEVEL` = 8, write 17 with no requests -> `overflow` = 1, `level` = 0 next cycle, FSM `IDLE`; the next SOF refills correctly.
- Full plus simultaneous pop/write: `level` = `DEPTH` in `STREAM`, one cycle with request and write -> `level` stays `DEPTH`, no overflow, oldest pixel output.
- Async reset: assert `RST_N` = 0 mid-stream between clock edges -> `RGB_out_valid` and `level` are 0 immediately; after release, SOF is required again.
